// File: rtl/piano_pkg.sv
// Shared constants and types for the Piano design: melody ROM geometry and note codes.
package piano_pkg;

    localparam int ROM_ADDR_W = 5;
    localparam int ROM_DATA_W = 4;
    localparam int ROM_DEPTH  = 32;

    typedef logic [3:0] note_t;

    // 8..15 are reserved codes and never appear in the melody table
    localparam note_t NOTE_REST = 4'd0;
    localparam note_t NOTE_C    = 4'd1;
    localparam note_t NOTE_D    = 4'd2;
    localparam note_t NOTE_E    = 4'd3;
    localparam note_t NOTE_F    = 4'd4;
    localparam note_t NOTE_G    = 4'd5;
    localparam note_t NOTE_A    = 4'd6;
    localparam note_t NOTE_B    = 4'd7;

endpackage

// File: rtl/note_rom.sv
// 32x4 melody ROM ("Twinkle Twinkle", 4 phrases of 8 steps) with a single registered output.
module note_rom
    import piano_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data
);

    note_t             w_note;
    logic [DATA_W-1:0] r_data;

    always_comb begin
        w_note = NOTE_REST;
        case (address)
            5'd0:  w_note = NOTE_C;
            5'd1:  w_note = NOTE_C;
            5'd2:  w_note = NOTE_G;
            5'd3:  w_note = NOTE_G;
            5'd4:  w_note = NOTE_A;
            5'd5:  w_note = NOTE_A;
            5'd6:  w_note = NOTE_G;
            5'd7:  w_note = NOTE_REST;
            5'd8:  w_note = NOTE_F;
            5'd9:  w_note = NOTE_F;
            5'd10: w_note = NOTE_E;
            5'd11: w_note = NOTE_E;
            5'd12: w_note = NOTE_D;
            5'd13: w_note = NOTE_D;
            5'd14: w_note = NOTE_C;
            5'd15: w_note = NOTE_REST;
            5'd16: w_note = NOTE_G;
            5'd17: w_note = NOTE_G;
            5'd18: w_note = NOTE_F;
            5'd19: w_note = NOTE_F;
            5'd20: w_note = NOTE_E;
            5'd21: w_note = NOTE_E;
            5'd22: w_note = NOTE_D;
            5'd23: w_note = NOTE_REST;
            5'd24: w_note = NOTE_G;
            5'd25: w_note = NOTE_G;
            5'd26: w_note = NOTE_F;
            5'd27: w_note = NOTE_F;
            5'd28: w_note = NOTE_E;
            5'd29: w_note = NOTE_E;
            5'd30: w_note = NOTE_D;
            5'd31: w_note = NOTE_REST;
            default: w_note = NOTE_REST;
        endcase
    end

    // Output register: one-cycle read latency, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= w_note;
        end
    end

    assign data = r_data;

endmodule

// File: tb/tb_note_rom.sv
// Directed bench for note_rom: reset, sweep with wrap, hold/latency, async reset, random reads.
module tb_note_rom;

    logic       clk;
    logic       rst_n;
    logic [4:0] address;
    logic [3:0] data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0] exp_rom [32] = '{
        4'd1, 4'd1, 4'd5, 4'd5, 4'd6, 4'd6, 4'd5, 4'd0,
        4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0,
        4'd5, 4'd5, 4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd0,
        4'd5, 4'd5, 4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd0
    };

    note_rom dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (address),
        .data    (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] exp);
        n_cmp++;
        assert (data === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, data, exp);
        end
    endtask

    task automatic check_legal(input string tag);
        n_cmp++;
        assert (data < 4'd8) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected code below 8", tag, data);
        end
    endtask

    // Apply address at the falling edge, then sample 1 ns after the next rising edge
    task automatic read_step(input logic [4:0] a, input string tag);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        check(tag, exp_rom[a]);
    endtask

    initial begin
        logic [4:0] step;
        logic [4:0] ra;

        rst_n   = 1'b0;
        address = 5'd0;

        // Reset held for 100 ns with the clock running
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_hold", 4'd0);
        end
        #1;
        rst_n = 1'b1;
        #1;
        check("after_release_no_edge", 4'd0);
        @(posedge clk);
        #1;
        check("first_edge_addr0", 4'd1);

        // Sweep 0..31 then wrap to 0 with a 5-bit counter
        step = 5'd0;
        for (int i = 0; i < 33; i++) begin
            read_step(step, "sweep");
            check_legal("sweep_legal");
            step = step + 5'd1;
        end

        // Spot checks from the hand-computed table
        read_step(5'd2,  "addr2");   check("addr2_lit",  4'd5);
        read_step(5'd4,  "addr4");   check("addr4_lit",  4'd6);
        read_step(5'd7,  "addr7");   check("addr7_lit",  4'd0);
        read_step(5'd14, "addr14");  check("addr14_lit", 4'd1);
        read_step(5'd22, "addr22");  check("addr22_lit", 4'd2);
        read_step(5'd31, "addr31");  check("addr31_lit", 4'd0);
        read_step(5'd0,  "wrap0");   check("wrap0_lit",  4'd1);

        // Latency and hold: address change between edges is invisible until next edge
        read_step(5'd8, "hold_addr8");
        check("hold_addr8_lit", 4'd4);
        @(negedge clk);
        address = 5'd2;
        #1;
        check("hold_mid_cycle", 4'd4);
        #3;
        check("hold_before_edge", 4'd4);
        @(posedge clk);
        #1;
        check("after_edge_addr2", 4'd5);

        // Asynchronous reset mid-sweep at address 20
        read_step(5'd20, "pre_reset_addr20");
        check("pre_reset_addr20_lit", 4'd3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 4'd0);
        @(posedge clk);
        #1;
        check("async_reset_over_edge", 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("async_release_no_edge", 4'd0);
        @(posedge clk);
        #1;
        check("after_release_addr20", 4'd3);

        // Random back-to-back reads
        for (int i = 0; i < 200; i++) begin
            ra = 5'($urandom_range(0, 31));
            read_step(ra, "random");
            check_legal("random_legal");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish before 200000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/note_rom.md
Name: note_rom

Overview:
- 32-entry by 4-bit read-only melody table for the Piano design.
- The player sequencer drives a 5-bit step index. The block returns the note code for that step, registered on the clock.
- Contents are a fixed melody ("Twinkle Twinkle", 4 phrases of 8 steps) encoded as note codes. No write port.

Parameters:
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 entries; fixed, contents are defined only for 5.
- DATA_W, 4, note code width; fixed, contents are defined only for 4.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- address  input  5  step index 0..31
- data  output  4  note code stored at the sampled address

Behaviour:
- Note codes:
  - 0 = rest.
  - 1..7 = C, D, E, F, G, A, B.
  - 8..15 are reserved and never stored.
- Contents, address 0..31, in order:
  - 0..7: 1 1 5 5 6 6 5 0
  - 8..15: 4 4 3 3 2 2 1 0
  - 16..23: 5 5 4 4 3 3 2 0
  - 24..31: 5 5 4 4 3 3 2 0
- Reset:
  - While rst_n = 0, data = 0, forced asynchronously (without waiting for clk).
  - On rst_n deassertion, data stays 0 until the first rising clk edge.
- Read:
  - On each rising clk edge with rst_n = 1, data takes the value ROM[address] as sampled at that edge.
  - Read latency is exactly 1 cycle; reads are back-to-back with full throughput.
  - data holds its value between edges. Address changes between edges have no effect until the next edge.
- Wrap-around:
  - The address is a full 5-bit range, so no out-of-range values exist.
  - Incrementing a step counter past 31 wraps naturally to 0; the block needs no special handling.
- X/Z on address: do not care; no output guarantee for that cycle.
- Reset mid-read: asynchronous reset wins over a coincident clk edge; data = 0.
- No internal state other than the data register.
- Synthesizes to LUT ROM or block ROM; either is acceptable as long as the latency is kept.

Decomposition:
- Shared package piano_pkg holds:
  - ROM_ADDR_W = 5, ROM_DATA_W = 4, ROM_DEPTH = 32.
  - Note code constants NOTE_REST = 0, NOTE_C = 1, NOTE_D = 2, NOTE_E = 3, NOTE_F = 4, NOTE_G = 5, NOTE_A = 6, NOTE_B = 7.
  - A note_t typedef (4-bit).
- The contents table is written using the NOTE_* constants.
- No sub-module; a single case-statement ROM feeding one output register.

Test Plan:
- Reset: hold rst_n = 0 for 100 ns with address = 0 and clock running -> data = 0 throughout; first edge after release -> data = 1.
- Full sweep: address increments 0..31, one per cycle -> data matches the table one cycle later, e.g. addr 2 -> 5, addr 4 -> 6, addr 7 -> 0, addr 14 -> 1, addr 22 -> 2, addr 31 -> 0.
- Wrap: 5-bit counter goes from 31 to 0 -> data sequence shows 0 (from addr 31) then 1 (from addr 0); no glitch or X.
- Latency and hold: change address from 8 to 2 mid-cycle -> data stays 4 until the next edge, then becomes 5.
- Async reset mid-sweep: assert rst_n = 0 at address 20, between edges -> data goes to 0 immediately, without a clock edge; after release and one edge -> data = ROM[current address].
- Random reads: 200 random addresses checked against a reference model of the table with 1-cycle delay -> zero mismatches; no value in 8..15 ever appears on data.
